// File: rtl/arc4_pkg.sv
// arc4_pkg: shared types for the ARC4 PRGA datapath
package arc4_pkg;
  localparam int SBOX_N = 256;
  typedef logic [$clog2(SBOX_N)-1:0] byte_t;
  typedef enum logic [3:0] {
    PS_IDLE, PS_INC_I, PS_WAIT_SI, PS_LATCH_SI, PS_ADDR_SJ,
    PS_WAIT_SJ, PS_SW1, PS_SW2, PS_PAD, PS_OUT
  } prga_state_t;
  typedef enum logic [2:0] {
    PH_IDLE, PH_RD_LEN, PH_WR_LEN, PH_RUN, PH_DONE
  } phase_t;
endpackage

// File: rtl/prga_swap_core.sv
// prga_swap_core: RC4 i/j update and S-box swap sequencer, one keystream byte per go request
//  clr_i      zero i and j for a new job
//  go_i/pad_i start a byte next cycle; pad_i selects a full byte (PAD/OUT) vs swap-only drop byte
//  s_*        S RAM port (read data valid the cycle after the address)
//  pad_o      PAD cycle of a full byte (caller presents the ciphertext address)
//  ks_vld_o   OUT cycle, ks_o carries the keystream byte
//  last_o     final cycle of the current byte; go_i here chains the next byte without a gap
module prga_swap_core
  import arc4_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clr_i,
  input  logic  go_i,
  input  logic  pad_i,
  output byte_t s_addr_o,
  input  byte_t s_rddata_i,
  output byte_t s_wrdata_o,
  output logic  s_wren_o,
  output logic  pad_o,
  output logic  ks_vld_o,
  output byte_t ks_o,
  output logic  last_o
);
  prga_state_t state_q, state_d;
  byte_t i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic pad_q, pad_d;
  assign ks_o = s_rddata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= PS_IDLE;
      i_q <= '0;
      j_q <= '0;
      si_q <= '0;
      sj_q <= '0;
      pad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      i_q <= i_d;
      j_q <= j_d;
      si_q <= si_d;
      sj_q <= sj_d;
      pad_q <= pad_d;
    end
  // The RAM re-reads every cycle, so wait states keep the address steady until the data is used.
  always_comb begin
    state_d = state_q;
    i_d = i_q;
    j_d = j_q;
    si_d = si_q;
    sj_d = sj_q;
    pad_d = go_i ? pad_i : pad_q;
    s_addr_o = '0;
    s_wrdata_o = '0;
    s_wren_o = 1'b0;
    pad_o = 1'b0;
    ks_vld_o = 1'b0;
    last_o = 1'b0;
    case (state_q)
      PS_IDLE: state_d = go_i ? PS_INC_I : PS_IDLE;
      PS_INC_I: begin
        s_addr_o = i_q + 8'd1;
        i_d = i_q + 8'd1;
        state_d = PS_WAIT_SI;
      end
      PS_WAIT_SI: begin
        s_addr_o = i_q;
        state_d = PS_LATCH_SI;
      end
      PS_LATCH_SI: begin
        s_addr_o = i_q;
        si_d = s_rddata_i;
        j_d = j_q + s_rddata_i;
        state_d = PS_ADDR_SJ;
      end
      PS_ADDR_SJ: begin
        s_addr_o = j_q;
        state_d = PS_WAIT_SJ;
      end
      PS_WAIT_SJ: begin
        s_addr_o = j_q;
        state_d = PS_SW1;
      end
      PS_SW1: begin
        sj_d = s_rddata_i;
        s_addr_o = i_q;
        s_wrdata_o = s_rddata_i;
        s_wren_o = 1'b1;
        state_d = PS_SW2;
      end
      PS_SW2: begin
        s_addr_o = j_q;
        s_wrdata_o = si_q;
        s_wren_o = 1'b1;
        last_o = !pad_q;
        state_d = pad_q ? PS_PAD : go_i ? PS_INC_I : PS_IDLE;
      end
      PS_PAD: begin
        s_addr_o = si_q + sj_q;
        pad_o = 1'b1;
        state_d = PS_OUT;
      end
      PS_OUT: begin
        ks_vld_o = 1'b1;
        last_o = 1'b1;
        state_d = go_i ? PS_INC_I : PS_IDLE;
      end
      default: state_d = PS_IDLE;
    endcase
    if (clr_i) begin
      i_d = '0;
      j_d = '0;
    end
  end
endmodule

// File: rtl/prga_drop.sv
// prga_drop: RC4-dropN keystream generator that decrypts a length-prefixed ciphertext RAM into a plaintext RAM
//  en/rdy     start handshake, accepted when rdy=1; rdy low while a job runs
//  err        sticky per job: length byte exceeded 2**ADDR_W-1, message truncated
//  s_*        S RAM port (KSA-scheduled S box, mutated in place)
//  ct_*       ciphertext RAM read port, ct[0] holds the length
//  pt_*       plaintext RAM write port, pt[0] receives the raw length
module prga_drop
  import arc4_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DROP_N = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic              rdy,
  output logic              err,
  output logic [7:0]        s_addr,
  input  logic [7:0]        s_rddata,
  output logic [7:0]        s_wrdata,
  output logic              s_wren,
  output logic [ADDR_W-1:0] ct_addr,
  input  logic [7:0]        ct_rddata,
  output logic [ADDR_W-1:0] pt_addr,
  output logic [7:0]        pt_wrdata,
  output logic              pt_wren
);
  localparam int KW = ADDR_W + 1;
  localparam logic [8:0] LMAX = 9'((1 << ADDR_W) - 1);
  localparam logic [10:0] DROP = 11'(DROP_N);
  phase_t ph_q, ph_d;
  logic [KW-1:0] k_q, k_d;
  logic [ADDR_W-1:0] leff_q, leff_d, len_now;
  logic [10:0] drop_q, drop_d;
  logic err_q, err_d, accept, len_over, more_drop, more_msg, go, pad_st, ks_vld, last;
  byte_t ks;
  prga_swap_core u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (accept),
    .go_i       (go),
    .pad_i      (!more_drop),
    .s_addr_o   (s_addr),
    .s_rddata_i (s_rddata),
    .s_wrdata_o (s_wrdata),
    .s_wren_o   (s_wren),
    .pad_o      (pad_st),
    .ks_vld_o   (ks_vld),
    .ks_o       (ks),
    .last_o     (last)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph_q <= PH_IDLE;
      k_q <= '0;
      leff_q <= '0;
      drop_q <= '0;
      err_q <= 1'b0;
    end else begin
      ph_q <= ph_d;
      k_q <= k_d;
      leff_q <= leff_d;
      drop_q <= drop_d;
      err_q <= err_d;
    end
  // Byte scheduling: drop bytes first, then message bytes; the next byte is requested in
  // WR_LEN or in the last cycle of the current byte so bytes run back to back.
  always_comb begin
    accept = ph_q == PH_IDLE && en;
    len_over = {1'b0, ct_rddata} > LMAX;
    len_now = len_over ? LMAX[ADDR_W-1:0] : ct_rddata[ADDR_W-1:0];
    leff_d = ph_q == PH_WR_LEN ? len_now : leff_q;
    more_drop = drop_q < DROP;
    more_msg = k_q < {1'b0, leff_d};
    go = (ph_q == PH_WR_LEN || last) && (more_drop || more_msg);
    drop_d = accept ? '0 : drop_q + 11'(go && more_drop);
    k_d = accept ? '0 : k_q + KW'(go && !more_drop);
    err_d = accept ? 1'b0 : ph_q == PH_WR_LEN ? len_over : err_q;
    ph_d = ph_q;
    case (ph_q)
      PH_IDLE: ph_d = en ? PH_RD_LEN : PH_IDLE;
      PH_RD_LEN: ph_d = PH_WR_LEN;
      PH_WR_LEN: ph_d = go ? PH_RUN : PH_DONE;
      PH_RUN: ph_d = last && !go ? PH_DONE : PH_RUN;
      default: ph_d = PH_IDLE;
    endcase
  end
  assign rdy = ph_q == PH_IDLE;
  assign err = err_q;
  assign ct_addr = pad_st ? k_q[ADDR_W-1:0] : '0;
  assign pt_wren = ph_q == PH_WR_LEN || ks_vld;
  assign pt_addr = ks_vld ? k_q[ADDR_W-1:0] : '0;
  assign pt_wrdata = ph_q == PH_WR_LEN ? ct_rddata : ks_vld ? ks ^ ct_rddata : '0;
endmodule
